// File: rtl/fetch_unit.sv
// Instruction-fetch stage: owns the PC, addresses instruction memory and fills the
// IF/ID register; honours stall/redirect and parks on ECALL/EBREAK until redirected.
module fetch_unit #(
  parameter int unsigned         ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]   RESET_PC = '0
) (
  input  logic              clk,
  input  logic              rst_n,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic [31:0]       imem_data,
  input  logic              stall,
  input  logic              redirect,
  input  logic [ADDR_W-1:0] redirect_pc,
  output logic              if_id_valid,
  output logic [ADDR_W-1:0] if_id_pc,
  output logic [ADDR_W-1:0] if_id_pc4,
  output logic [31:0]       if_id_inst,
  output logic              halted
);

  localparam int unsigned INST_W = 32;
  localparam logic [INST_W-1:0] ECALL  = 32'h0000_0073;
  localparam logic [INST_W-1:0] EBREAK = 32'h0010_0073;

  typedef enum logic {ST_RUN, ST_HALT} state_t;

  state_t              r_state;
  logic [ADDR_W-1:0]   r_pc;
  logic                r_valid;
  logic [ADDR_W-1:0]   r_id_pc;
  logic [ADDR_W-1:0]   r_id_pc4;
  logic [INST_W-1:0]   r_id_inst;

  state_t              w_state_nxt;
  logic [ADDR_W-1:0]   w_pc_nxt;
  logic                w_valid_nxt;
  logic [ADDR_W-1:0]   w_id_pc_nxt;
  logic [ADDR_W-1:0]   w_id_pc4_nxt;
  logic [INST_W-1:0]   w_id_inst_nxt;
  logic [ADDR_W-1:0]   w_pc_plus4;
  logic [ADDR_W-1:0]   w_redirect_aligned;
  logic                w_is_halt_inst;

  assign w_pc_plus4         = r_pc + ADDR_W'(4);
  assign w_redirect_aligned = redirect_pc & ~ADDR_W'(3);
  assign w_is_halt_inst     = (imem_data == ECALL) || (imem_data == EBREAK);

  // State and pipeline register update; reset overrides every other input.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state   <= ST_RUN;
      r_pc      <= RESET_PC;
      r_valid   <= 1'b0;
      r_id_pc   <= '0;
      r_id_pc4  <= '0;
      r_id_inst <= '0;
    end else begin
      r_state   <= w_state_nxt;
      r_pc      <= w_pc_nxt;
      r_valid   <= w_valid_nxt;
      r_id_pc   <= w_id_pc_nxt;
      r_id_pc4  <= w_id_pc4_nxt;
      r_id_inst <= w_id_inst_nxt;
    end
  end

  // Next-state: redirect beats halt, halt beats stall, stall beats fetch.
  always_comb begin
    w_state_nxt   = r_state;
    w_pc_nxt      = r_pc;
    w_valid_nxt   = r_valid;
    w_id_pc_nxt   = r_id_pc;
    w_id_pc4_nxt  = r_id_pc4;
    w_id_inst_nxt = r_id_inst;

    if (redirect) begin
      w_pc_nxt    = w_redirect_aligned;
      w_valid_nxt = 1'b0;
      w_state_nxt = ST_RUN;
    end else begin
      case (r_state)
        ST_HALT: begin
          if (!stall) w_valid_nxt = 1'b0;
        end
        default: begin
          if (!stall) begin
            w_id_inst_nxt = imem_data;
            w_id_pc_nxt   = r_pc;
            w_id_pc4_nxt  = w_pc_plus4;
            w_valid_nxt   = 1'b1;
            // A halting instruction is still delivered, but the PC parks on it.
            if (w_is_halt_inst) w_state_nxt = ST_HALT;
            else                w_pc_nxt    = w_pc_plus4;
          end
        end
      endcase
    end
  end

  assign imem_addr   = r_pc;
  assign if_id_valid = r_valid;
  assign if_id_pc    = r_id_pc;
  assign if_id_pc4   = r_id_pc4;
  assign if_id_inst  = r_id_inst;
  assign halted      = (r_state == ST_HALT);

endmodule
